// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: requester and fpu-side handshake bundle for fpu_arbiter.
//   master : requester/fpu environment view (drives requests, acks, fpu handshake inputs)
//   slave  : arbiter view (drives req_ready, responses, fpu command/operands)
// Optional rsp_err signal exists only when FPU_ARB_TIMEOUT_EN is defined.
interface fpu_arbiter_if #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CMD_WIDTH = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
  logic [NUM_REQ*WIDTH-1:0]     req_a;
  logic [NUM_REQ*WIDTH-1:0]     req_b;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [WIDTH-1:0]             rsp_result;
  logic [NUM_REQ-1:0]           rsp_ack;
`ifdef FPU_ARB_TIMEOUT_EN
  logic                         rsp_err;
`endif
  logic [CMD_WIDTH-1:0]         fpu_command;
  logic [WIDTH-1:0]             fpu_data_a;
  logic [WIDTH-1:0]             fpu_data_b;
  logic                         fpu_input_rdy;
  logic                         fpu_input_ack;
  logic                         fpu_output_rdy;
  logic                         fpu_output_ack;
  logic [WIDTH-1:0]             fpu_result;
  logic [1:0]                   grant_id;
  logic                         busy;

  modport master (
    output req_valid, req_cmd, req_a, req_b, rsp_ack,
           fpu_input_ack, fpu_output_rdy, fpu_result,
`ifdef FPU_ARB_TIMEOUT_EN
    input  rsp_err,
`endif
    input  req_ready, rsp_valid, rsp_result, fpu_command, fpu_data_a, fpu_data_b,
           fpu_input_rdy, fpu_output_ack, grant_id, busy
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, rsp_ack,
           fpu_input_ack, fpu_output_rdy, fpu_result,
`ifdef FPU_ARB_TIMEOUT_EN
    output rsp_err,
`endif
    output req_ready, rsp_valid, rsp_result, fpu_command, fpu_data_a, fpu_data_b,
           fpu_input_rdy, fpu_output_ack, grant_id, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one fpu between NUM_REQ requesters, one operation at a time.
// A round-robin winner is chosen in IDLE, its command/operands are registered and
// issued to the fpu, the fpu result is captured and held for the owning requester
// until it acknowledges.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-high reset (shared with the fpu)
//   bus    : fpu_arbiter_if.slave (requester handshake, response, fpu handshake,
//            grant_id, busy)
// Optional feature macro FPU_ARB_TIMEOUT_EN: adds rsp_err and a watchdog that
// forces an error response after TIMEOUT_CYCLES cycles in ISSUE/WAIT.
// Parameters must match those of the connected interface instance.
module fpu_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned CMD_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clock,
  input  logic         reset,
  fpu_arbiter_if.slave bus
);

  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = 8;

  // Reject configurations the 2-bit grant id / 8-bit watchdog cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("fpu_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_result_q, rsp_result_d;
  logic                 in_rdy_q, in_rdy_d;
  logic                 out_ack_q, out_ack_d;
  logic                 busy_q, busy_d;
  logic                 early_q, early_d;
  logic [WIDTH-1:0]     early_res_q, early_res_d;
`ifdef FPU_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  logic                 pick_found;
  logic [ID_W-1:0]      pick_idx;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [CMD_WIDTH-1:0] sel_cmd;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;
  logic                 own_ack;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == idx) v[j] = 1'b1;
    end
    return v;
  endfunction

  // Round robin: rotate requests so the pointer sits at bit 0, take the first set bit.
  always_comb begin
    req_dbl    = {bus.req_valid, bus.req_valid};
    req_rot    = NUM_REQ'(req_dbl >> ptr_q);
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!pick_found && req_rot[j]) begin
        pick_found = 1'b1;
        pick_idx   = (32'(ptr_q) + j >= NUM_REQ) ? ID_W'(32'(ptr_q) + j - NUM_REQ)
                                                 : ID_W'(32'(ptr_q) + j);
      end
    end
  end

  // Winner's command/operand slice.
  always_comb begin
    sel_cmd = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == pick_idx) begin
        sel_cmd = bus.req_cmd[j*CMD_WIDTH +: CMD_WIDTH];
        sel_a   = bus.req_a[j*WIDTH +: WIDTH];
        sel_b   = bus.req_b[j*WIDTH +: WIDTH];
      end
    end
  end

  // Only the owner's rsp_valid bit is ever set, so masking ignores other acks.
  assign own_ack = |(bus.rsp_ack & rsp_valid_q);

  // Next-state and registered-output values.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    cmd_d        = cmd_q;
    a_d          = a_q;
    b_d          = b_q;
    req_ready_d  = '0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    out_ack_d    = 1'b0;
    early_d      = early_q;
    early_res_d  = early_res_q;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          cmd_d       = sel_cmd;
          a_d         = sel_a;
          b_d         = sel_b;
          req_ready_d = onehot(pick_idx);
          early_d     = 1'b0;
          state_d     = ISSUE;
`ifdef FPU_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ISSUE: begin
        if (bus.fpu_input_ack) begin
          state_d = WAIT;
          // A result presented together with the input ack is kept for WAIT.
          if (bus.fpu_output_rdy) begin
            early_d     = 1'b1;
            early_res_d = bus.fpu_result;
          end
        end
      end
      WAIT: begin
        if (early_q || bus.fpu_output_rdy) begin
          rsp_result_d = early_q ? early_res_q : bus.fpu_result;
          rsp_valid_d  = onehot(grant_q);
          out_ack_d    = 1'b1;
          early_d      = 1'b0;
          state_d      = DELIVER;
        end
      end
      DELIVER: begin
        if (own_ack) begin
          rsp_valid_d  = '0;
          rsp_result_d = '0;
          ptr_d        = (32'(grant_q) + 32'd1 >= NUM_REQ) ? '0 : grant_q + ID_W'(1);
          state_d      = IDLE;
`ifdef FPU_ARB_TIMEOUT_EN
          err_d        = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FPU_ARB_TIMEOUT_EN
    // Watchdog overrides any capture in the same cycle.
    if (state_q == ISSUE || state_q == WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
        rsp_result_d = '0;
        rsp_valid_d  = onehot(grant_q);
        out_ack_d    = 1'b0;
        early_d      = 1'b0;
        err_d        = 1'b1;
        state_d      = DELIVER;
      end
    end
`endif

    in_rdy_d = (state_d == ISSUE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      cmd_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      in_rdy_q     <= 1'b0;
      out_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      early_q      <= 1'b0;
      early_res_q  <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      cmd_q        <= cmd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      in_rdy_q     <= in_rdy_d;
      out_ack_q    <= out_ack_d;
      busy_q       <= busy_d;
      early_q      <= early_d;
      early_res_q  <= early_res_d;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_result     = rsp_result_q;
  assign bus.fpu_command    = cmd_q;
  assign bus.fpu_data_a     = a_q;
  assign bus.fpu_data_b     = b_q;
  assign bus.fpu_input_rdy  = in_rdy_q;
  assign bus.fpu_output_ack = out_ack_q;
  assign bus.grant_id       = grant_q;
  assign bus.busy           = busy_q;
`ifdef FPU_ARB_TIMEOUT_EN
  assign bus.rsp_err        = err_q;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: scoreboard bench for fpu_arbiter with a behavioural fpu stub.
module tb_fpu_arbiter;

  logic clock;
  logic reset;

  fpu_arbiter_if #(.NUM_REQ(2), .WIDTH(32), .CMD_WIDTH(4)) bus ();

  fpu_arbiter #(.NUM_REQ(2), .WIDTH(32), .CMD_WIDTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] res;
    logic        err;
    logic        oack;
  } exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int first_ready_cyc;
  logic [1:0] first_ready_vec;

  int stub_lat   = 2;
  bit stub_pulse = 1'b0;
  bit stub_hang  = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fpu_model(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b);
    if (cmd == 4'd0 && a == 32'h3F80_0000 && b == 32'h3C23_D70A) return 32'h3F81_47AE;
    if (cmd == 4'd0 && a == 32'h41D0_0000 && b == 32'h41E8_0000) return 32'h425C_0000;
    return a ^ {b[15:0], b[31:16]} ^ {28'h0, cmd};
  endfunction

  // fpu stub: acks input, returns the result after stub_lat cycles.
  initial begin : fpu_stub
    int st;
    int cnt;
    logic [31:0] res;
    st = 0; cnt = 0; res = '0;
    bus.fpu_input_ack  = 1'b0;
    bus.fpu_output_rdy = 1'b0;
    bus.fpu_result     = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        st = 0;
        bus.fpu_input_ack  = 1'b0;
        bus.fpu_output_rdy = 1'b0;
        bus.fpu_result     = '0;
      end else begin
        case (st)
          0: if (bus.fpu_input_rdy && !stub_hang) begin
               bus.fpu_input_ack = 1'b1;
               res = fpu_model(bus.fpu_command, bus.fpu_data_a, bus.fpu_data_b);
               if (stub_lat == 0) begin
                 bus.fpu_output_rdy = 1'b1; bus.fpu_result = res; st = 2;
               end else begin
                 cnt = stub_lat; st = 1;
               end
             end
          1: begin
               bus.fpu_input_ack = 1'b0;
               cnt--;
               if (cnt == 0) begin
                 bus.fpu_output_rdy = 1'b1; bus.fpu_result = res; st = 2;
               end
             end
          default: begin
               bus.fpu_input_ack = 1'b0;
               if (bus.fpu_output_ack || stub_pulse) begin
                 bus.fpu_output_rdy = 1'b0; bus.fpu_result = '0; st = 0;
               end
             end
        endcase
      end
    end
  end

  task automatic drive_reqs();
    bus.req_valid = '0;
    if (q0.size() != 0) begin
      bus.req_valid[0] = 1'b1;
      bus.req_cmd[3:0] = q0[0].cmd; bus.req_a[31:0] = q0[0].a; bus.req_b[31:0] = q0[0].b;
    end else begin
      bus.req_cmd[3:0] = 4'($urandom); bus.req_a[31:0] = $urandom; bus.req_b[31:0] = $urandom;
    end
    if (q1.size() != 0) begin
      bus.req_valid[1] = 1'b1;
      bus.req_cmd[7:4] = q1[0].cmd; bus.req_a[63:32] = q1[0].a; bus.req_b[63:32] = q1[0].b;
    end else begin
      bus.req_cmd[7:4] = 4'($urandom); bus.req_a[63:32] = $urandom; bus.req_b[63:32] = $urandom;
    end
  endtask

  // Call in expected grant order: the queue order is the expected response order.
  task automatic add_op(input int idx, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res);
    op_t o;
    exp_t e;
    o.cmd = cmd; o.a = a; o.b = b;
    if (idx == 0) q0.push_back(o); else q1.push_back(o);
    e.idx = 2'(idx); e.res = res; e.err = 1'b0; e.oack = 1'b1;
    sb.push_back(e);
  endtask

  task automatic run_ops(input int ack_delay, input int budget);
    int cyc, wait_cnt, ack_cnt, unstable;
    bit acking;
    logic [1:0] snap_v;
    logic [31:0] snap_r;
    exp_t e;
    cyc = 0; wait_cnt = 0; ack_cnt = 0; unstable = 0; acking = 1'b0;
    snap_v = '0; snap_r = '0;
    first_ready_cyc = -1; first_ready_vec = '0;
    drive_reqs();
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && cyc < budget) begin
      @(posedge clock); #1;
      cyc++;
      if (acking) begin bus.rsp_ack = '0; acking = 1'b0; end
      if (bus.fpu_output_ack) ack_cnt++;
      if (bus.req_ready != '0 && first_ready_cyc < 0) begin
        first_ready_cyc = cyc; first_ready_vec = bus.req_ready;
      end
      if (bus.req_ready[0] && q0.size() != 0) void'(q0.pop_front());
      if (bus.req_ready[1] && q1.size() != 0) void'(q1.pop_front());
      drive_reqs();
      if (bus.rsp_valid != '0) begin
        if (wait_cnt == 0) begin
          snap_v = bus.rsp_valid; snap_r = bus.rsp_result;
        end else if (bus.rsp_valid != snap_v || bus.rsp_result != snap_r ||
                     bus.req_ready != '0 || !bus.busy) begin
          unstable++;
        end
        if (wait_cnt >= ack_delay && sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_valid_owner", 64'(bus.rsp_valid), 64'(2'b01 << e.idx));
          check("rsp_result", 64'(bus.rsp_result), 64'(e.res));
          check("grant_id", 64'(bus.grant_id), 64'(e.idx));
          check("fpu_output_ack_count", 64'(ack_cnt), 64'(e.oack));
`ifdef FPU_ARB_TIMEOUT_EN
          check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
`endif
          if (ack_delay > 0) check("backpressure_stable", 64'(unstable), 64'd0);
          bus.rsp_ack = bus.rsp_valid;
          acking = 1'b1; wait_cnt = 0; ack_cnt = 0; unstable = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
    check("ops_within_budget", 64'(sb.size() + q0.size() + q1.size()), 64'd0);
    sb.delete(); q0.delete(); q1.delete();
    if (acking) begin @(posedge clock); #1; bus.rsp_ack = '0; end
    drive_reqs();
    check("rsp_idle_valid", 64'(bus.rsp_valid), 64'd0);
    check("rsp_idle_result", 64'(bus.rsp_result), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'd0);
    check({tag, "_fpu_input_rdy"}, 64'(bus.fpu_input_rdy), 64'd0);
    check({tag, "_fpu_output_ack"}, 64'(bus.fpu_output_ack), 64'd0);
    check({tag, "_fpu_command"}, 64'(bus.fpu_command), 64'd0);
    check({tag, "_fpu_data"}, {bus.fpu_data_a, bus.fpu_data_b}, 64'd0);
    check({tag, "_grant_id"}, 64'(bus.grant_id), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin : main
    bit seen;
    bit reached;
    exp_t e;
    reset = 1'b1;
    bus.req_valid = '0; bus.req_cmd = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ack = '0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Single requester add with 1-cycle accept latency.
    stub_lat = 3;
    add_op(0, 4'd0, 32'h3F80_0000, 32'h3C23_D70A, 32'h3F81_47AE);
    run_ops(0, 100);
    check("req_ready_latency", 64'(first_ready_cyc), 64'd1);
    check("req_ready_vec", 64'(first_ready_vec), 64'd1);

    // Normalising add on requester 1.
    stub_lat = 2;
    add_op(1, 4'd0, 32'h41D0_0000, 32'h41E8_0000, 32'h425C_0000);
    run_ops(0, 100);

    // Contention: both valid, expect 0,1,0,1.
    stub_lat = 1;
    add_op(0, 4'd1, 32'h1111_2222, 32'h3333_4444, fpu_model(4'd1, 32'h1111_2222, 32'h3333_4444));
    add_op(1, 4'd2, 32'hAAAA_5555, 32'h0F0F_F0F0, fpu_model(4'd2, 32'hAAAA_5555, 32'h0F0F_F0F0));
    add_op(0, 4'd3, 32'hDEAD_BEEF, 32'h0123_4567, fpu_model(4'd3, 32'hDEAD_BEEF, 32'h0123_4567));
    add_op(1, 4'd4, 32'hCAFE_F00D, 32'h89AB_CDEF, fpu_model(4'd4, 32'hCAFE_F00D, 32'h89AB_CDEF));
    run_ops(1, 200);

    // Response back-pressure with another request pending.
    stub_lat = 2;
    add_op(0, 4'd5, 32'h4000_0000, 32'h4040_0000, fpu_model(4'd5, 32'h4000_0000, 32'h4040_0000));
    add_op(1, 4'd6, 32'h7F7F_0001, 32'h0000_8001, fpu_model(4'd6, 32'h7F7F_0001, 32'h0000_8001));
    run_ops(10, 200);

    // Result presented for one cycle together with the input ack.
    stub_lat = 0; stub_pulse = 1'b1;
    add_op(0, 4'd7, 32'h5555_AAAA, 32'h1234_5678, fpu_model(4'd7, 32'h5555_AAAA, 32'h1234_5678));
    run_ops(0, 100);
    stub_pulse = 1'b0;

    // Reset in WAIT (pointer is 1 here), then pointer must restart at 0.
    stub_lat = 30;
    add_op(1, 4'd8, 32'h0BAD_0BAD, 32'h600D_600D, 32'h0);
    sb.delete();
    drive_reqs();
    seen = 1'b0; reached = 1'b0;
    for (int c = 0; c < 60 && !reached; c++) begin
      @(posedge clock); #1;
      if (bus.req_ready[1] && q1.size() != 0) begin
        void'(q1.pop_front()); drive_reqs(); seen = 1'b1;
      end else if (seen && bus.busy && !bus.fpu_input_rdy) begin
        reached = 1'b1;
      end
    end
    check("reached_wait", 64'(reached), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid_reset");
    q0.delete(); q1.delete(); drive_reqs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    stub_lat = 2;
    add_op(0, 4'd9, 32'h0000_0001, 32'h0000_0002, fpu_model(4'd9, 32'h0000_0001, 32'h0000_0002));
    add_op(1, 4'd10, 32'hFFFF_0000, 32'h00FF_FF00, fpu_model(4'd10, 32'hFFFF_0000, 32'h00FF_FF00));
    run_ops(0, 200);

`ifdef FPU_ARB_TIMEOUT_EN
    // Watchdog: fpu never accepts, ptr is 0 here.
    stub_hang = 1'b1;
    add_op(0, 4'd11, 32'h1234_0000, 32'h0000_4321, 32'h0);
    e = sb.pop_back();
    e.err = 1'b1; e.oack = 1'b0;
    sb.push_back(e);
    run_ops(0, 150);
    stub_hang = 1'b0;
`else
    e = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
